// File: rtl/apb_multi_clk_counter.sv
// NUM_CH software-run p_clk cycle counters on a zero-wait APB slave; optional APB_CLK_COUNTER_IRQ_EN adds CMP/IE/irq.
// Latency: writes act on the access edge, read data registers at the setup edge; no backpressure (p_ready tied high).
module apb_multi_clk_counter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 12
) (
  input  logic        p_clk,
  input  logic        prst_n,
  input  logic [31:0] p_addr,
  input  logic        p_sel,
  input  logic        p_en,
  input  logic        p_write,
  input  logic [31:0] p_wrdata,
  output logic        p_ready,
  output logic [31:0] p_rdata,
  output logic        p_slverr
`ifdef APB_CLK_COUNTER_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int IDX_W = ADDR_W - 4;
  localparam logic [IDX_W-1:0] GIDX = IDX_W'(NUM_CH);
  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CNT  = 2'd2;
  localparam logic [1:0] OFF_INFO = 2'd3;
`ifdef APB_CLK_COUNTER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2} st_e;

  st_e                st_q   [NUM_CH];
  st_e                st_d   [NUM_CH];
  logic [CNT_W-1:0]   cnt_q  [NUM_CH];
  logic [CNT_W-1:0]   cnt_d  [NUM_CH];
  logic [NUM_CH-1:0]  ovf_q, ovf_d;
  logic [NUM_CH-1:0]  hit_q, hit_d;
  logic [NUM_CH-1:0]  ie_q, ie_d;
  logic [CNT_W-1:0]   cmp_q  [NUM_CH];
  logic [CNT_W-1:0]   cmp_d  [NUM_CH];
  logic [31:0]        rdata_q, rdata_d, rd_val;
  logic [NUM_CH-1:0]  start_c, stop_c, clr_c;
  logic [CNT_W:0]     inc;
  logic [4:0]         stat;

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             is_ch, is_g, dec_err, wr_err, err, wr_ok, setup;
  logic             unused_wdata;

  assign idx     = p_addr[ADDR_W-1:4];
  assign off     = p_addr[3:2];
  assign is_ch   = (idx < GIDX);
  assign is_g    = (idx == GIDX) && (off == OFF_CTRL);
  assign dec_err = (p_addr[31:ADDR_W] != '0) || (p_addr[1:0] != 2'b00) || !(is_ch || is_g);
  assign wr_err  = p_write && is_ch &&
                   ((off == OFF_CNT) ||
                    (!HAS_IRQ && ((off == OFF_STAT) || (off == OFF_INFO))) ||
                    ((off == OFF_CTRL) && p_wrdata[0] && p_wrdata[1]));
  assign err     = dec_err || wr_err;
  assign wr_ok   = p_sel && p_en && p_write && !err;
  assign setup   = p_sel && !p_en;

  assign p_ready      = 1'b1;
  assign p_slverr     = p_sel && p_en && err;
  assign p_rdata      = rdata_q;
  assign unused_wdata = ^p_wrdata;
`ifdef APB_CLK_COUNTER_IRQ_EN
  assign irq = |(hit_q & ie_q);
`endif

  // GCTRL with both start and stop set for a channel leaves that channel alone.
  always_comb begin
    start_c = '0;
    stop_c  = '0;
    clr_c   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ok && is_ch && (idx == IDX_W'(c)) && (off == OFF_CTRL)) begin
        start_c[c] = p_wrdata[0];
        stop_c[c]  = p_wrdata[1];
        clr_c[c]   = p_wrdata[2];
      end
      if (wr_ok && is_g && (p_wrdata[c] != p_wrdata[16+c])) begin
        start_c[c] = p_wrdata[c];
        stop_c[c]  = p_wrdata[16+c];
      end
    end
  end

  always_comb begin
    inc   = '0;
    ovf_d = ovf_q;
    hit_d = hit_q;
    ie_d  = ie_q;
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]  = st_q[c];
      cnt_d[c] = cnt_q[c];
      cmp_d[c] = cmp_q[c];
      if (st_q[c] == ST_RUN) begin
        inc      = {1'b0, cnt_q[c]} + (CNT_W+1)'(1);
        cnt_d[c] = inc[CNT_W-1:0];
        if (inc[CNT_W]) ovf_d[c] = 1'b1;
      end
      if (HAS_IRQ && wr_ok && is_ch && (idx == IDX_W'(c))) begin
        if (off == OFF_CTRL) ie_d[c] = p_wrdata[3];
        if ((off == OFF_STAT) && p_wrdata[4]) hit_d[c] = 1'b0;
        if (off == OFF_INFO) cmp_d[c] = p_wrdata[CNT_W-1:0];
      end
      if (HAS_IRQ && (st_q[c] == ST_RUN) && (cnt_d[c] == cmp_q[c])) hit_d[c] = 1'b1;
      if (clr_c[c]) begin
        st_d[c]  = ST_IDLE;
        cnt_d[c] = '0;
        ovf_d[c] = 1'b0;
      end else if (stop_c[c]) begin
        if (st_q[c] == ST_RUN) st_d[c] = ST_HALT;
      end else if (start_c[c]) begin
        st_d[c] = ST_RUN;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    stat   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!dec_err && is_ch && (idx == IDX_W'(c))) begin
        stat = {hit_q[c], st_q[c], ovf_q[c], st_q[c] == ST_RUN};
        case (off)
          OFF_STAT: rd_val = 32'(stat);
          OFF_CNT:  rd_val = 32'(cnt_q[c]);
          OFF_INFO: rd_val = HAS_IRQ ? 32'(cmp_q[c]) : {8'(c), 8'(NUM_CH), 16'(CNT_W)};
          default:  rd_val = '0;
        endcase
      end
    end
    rdata_d = setup ? rd_val : rdata_q;
  end

  always_ff @(posedge p_clk) begin
    if (!prst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]  <= ST_IDLE;
        cnt_q[c] <= '0;
        cmp_q[c] <= '0;
      end
      ovf_q   <= '0;
      hit_q   <= '0;
      ie_q    <= '0;
      rdata_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]  <= st_d[c];
        cnt_q[c] <= cnt_d[c];
        cmp_q[c] <= cmp_d[c];
      end
      ovf_q   <= ovf_d;
      hit_q   <= hit_d;
      ie_q    <= ie_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
